// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared SECDED sizing helpers, scrubber FSM states and error types
package ecc_pkg;

  // Smallest m with 2**m >= m + k + 1 (Hamming parity bits for k data bits).
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  // Full codeword width including the overall parity bit.
  function automatic int calc_n(input int k);
    return k + calc_m(k) + 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHK,
    WB,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SEC,
    ERR_DED
  } err_t;

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// rtl/ecc_scrub_ctrl_if.sv - shared memory port and host arbitration signals of the scrubber
interface ecc_scrub_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int N      = 8
);
  logic              i_host_req;
  logic              o_host_gnt;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [N-1:0]      o_mem_wdata;
  logic [N-1:0]      i_mem_rdata;

  modport master (
    input  i_host_req,
    input  i_mem_rdata,
    output o_host_gnt,
    output o_mem_en,
    output o_mem_we,
    output o_mem_addr,
    output o_mem_wdata
  );

  modport slave (
    output i_host_req,
    output i_mem_rdata,
    input  o_host_gnt,
    input  o_mem_en,
    input  o_mem_we,
    input  o_mem_addr,
    input  o_mem_wdata
  );
endinterface

// File: rtl/secded_dec.sv
// rtl/secded_dec.sv - combinational SECDED decoder over the full codeword
module secded_dec
  import ecc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] cw,
  output logic [N-1:0] corrected,
  output logic         sec,
  output logic         ded
);
  // Bit 0 is the overall parity; bits 1..N-1 sit at their Hamming positions.
  localparam int SW = $clog2(N);

  logic [SW-1:0] syn;
  logic          par;

  // Syndrome is the XOR of the positions of all set bits; a nonzero syndrome
  // with even overall parity can only be a double error.
  always_comb begin
    syn       = '0;
    par       = ^cw;
    corrected = cw;
    sec       = 1'b0;
    ded       = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (cw[i]) syn = syn ^ SW'(i);
    end
    if (par) begin
      sec = 1'b1;
      if (syn == '0) begin
        corrected[0] = ~cw[0];
      end else if (int'(syn) < N) begin
        corrected[syn] = ~cw[syn];
      end
    end else if (syn != '0) begin
      ded = 1'b1;
    end
  end
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background SECDED scrubber sharing one memory port with a host
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int K      = 4,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_clr,
  ecc_scrub_ctrl_if.master  mem,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_sec_cnt,
  output logic [CNT_W-1:0]  o_ded_cnt,
  output logic              o_ded_valid,
  output logic [ADDR_W-1:0] o_ded_addr
);
  localparam int M = calc_m(K);
  localparam int N = K + M + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [N-1:0]      cw_q;
  logic [N-1:0]      wdata_q;
  logic [CNT_W-1:0]  sec_q;
  logic [CNT_W-1:0]  ded_q;
  logic              ded_valid_q;
  logic [ADDR_W-1:0] ded_addr_q;

  logic [N-1:0]      dec_cw;
  logic              dec_sec;
  logic              dec_ded;
  err_t              chk_err;
  logic              host_free;

  secded_dec #(.N(N)) u_dec (
    .cw        (cw_q),
    .corrected (dec_cw),
    .sec       (dec_sec),
    .ded       (dec_ded)
  );

  assign chk_err = dec_ded ? ERR_DED : (dec_sec ? ERR_SEC : ERR_NONE);

  // The host gets the port whenever no read-check-writeback is in flight.
  // Grant and the REQ strobe depend on i_host_req in the same cycle, so they
  // are decoded from the state register rather than registered themselves.
  assign host_free       = (state == IDLE) || (state == REQ) || (state == DONE);
  assign mem.o_host_gnt  = i_rst_n & host_free & mem.i_host_req;
  assign mem.o_mem_en    = ((state == REQ) && !mem.i_host_req) || (state == WB);
  assign mem.o_mem_we    = (state == WB);
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;

  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign o_sec_cnt   = sec_q;
  assign o_ded_cnt   = ded_q;
  assign o_ded_valid = ded_valid_q;
  assign o_ded_addr  = ded_addr_q;

  // Scrub sequencing, error bookkeeping; a clear overrides any same-cycle update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      cw_q        <= '0;
      wdata_q     <= '0;
      sec_q       <= '0;
      ded_q       <= '0;
      ded_valid_q <= 1'b0;
      ded_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= REQ;
            addr_q <= '0;
          end
        end
        REQ: begin
          if (!mem.i_host_req) state <= WAIT;
        end
        WAIT: begin
          cw_q  <= mem.i_mem_rdata;
          state <= CHK;
        end
        CHK: begin
          wdata_q <= dec_cw;
          if (chk_err == ERR_SEC) begin
            if (sec_q != CNT_MAX) sec_q <= sec_q + 1'b1;
            state <= WB;
          end else begin
            if (chk_err == ERR_DED) begin
              if (ded_q != CNT_MAX) ded_q <= ded_q + 1'b1;
              if (!ded_valid_q) begin
                ded_valid_q <= 1'b1;
                ded_addr_q  <= addr_q;
              end
            end
            if (addr_q == LAST_ADDR) begin
              state <= DONE;
            end else begin
              addr_q <= addr_q + 1'b1;
              state  <= REQ;
            end
          end
        end
        WB: begin
          if (addr_q == LAST_ADDR) begin
            state <= DONE;
          end else begin
            addr_q <= addr_q + 1'b1;
            state  <= REQ;
          end
        end
        DONE: begin
          state  <= IDLE;
          addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
      if (i_clr) begin
        sec_q       <= '0;
        ded_q       <= '0;
        ded_valid_q <= 1'b0;
        ded_addr_q  <= '0;
      end
    end
  end
endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for a SECDED-protected memory. It walks every address, reads each codeword and decodes it. Single-bit errors are written back corrected. Double-bit errors are logged and flagged to software.
It shares the single memory port with a host requester; the host has priority except during an atomic read-check-writeback.

Parameters:
K, 4, data bits per word
M, derived: smallest m with 2**m >= m+K+1 (3 for K=4), Hamming parity bits
N, K+M+1 (8 for K=4), codeword width including overall parity bit
ADDR_W, 4, memory address width; scrub range 0..2**ADDR_W-1
CNT_W, 8, error counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  pulse: begin one full scrub pass (ignored while busy)
i_clr  in  1  pulse: clear counters and DED log
i_host_req  in  1  host wants the memory port
o_host_gnt  out  1  host owns memory port this cycle
o_mem_en  out  1  scrubber memory access strobe
o_mem_we  out  1  scrubber write enable
o_mem_addr  out  ADDR_W  scrubber address
o_mem_wdata  out  N  corrected codeword for writeback
i_mem_rdata  in  N  read data, valid 1 cycle after o_mem_en & !o_mem_we
o_busy  out  1  pass in progress
o_done  out  1  1-cycle pulse at end of pass
o_sec_cnt  out  CNT_W  corrected single-bit errors, saturating
o_ded_cnt  out  CNT_W  detected double-bit errors, saturating
o_ded_valid  out  1  sticky: at least one DED logged
o_ded_addr  out  ADDR_W  address of first DED since clear

Behaviour:
- Reset values (async, i_rst_n=0): FSM=IDLE; address=0; all outputs 0.
- FSM states: IDLE, REQ, WAIT, CHK, WB, DONE.
- IDLE: o_host_gnt=i_host_req. On i_start go to REQ with address 0.
- REQ:
  - If i_host_req=1: o_host_gnt=1, o_mem_en=0, stay in REQ (stall, no timeout).
  - Else: o_mem_en=1, o_mem_we=0, go to WAIT.
- WAIT: one cycle for read latency; o_host_gnt=0 even if host requests. Latch i_mem_rdata at end of this cycle.
- CHK: decode the latched codeword via the sub-module; result is registered into state this cycle.
  - No error: go to advance.
  - Single-bit error (including error in the overall parity bit): sec_cnt+1, go to WB.
  - Double-bit error: ded_cnt+1; if o_ded_valid=0, capture address and set o_ded_valid; go to advance (no writeback).
- WB: o_mem_en=1, o_mem_we=1, o_mem_wdata=corrected codeword, same address; then advance.
- Advance: if address==2**ADDR_W-1 go to DONE, else address+1 and go to REQ. No wrap within a pass.
- DONE: o_done=1 for one cycle; return to IDLE; address resets to 0.
- o_busy=1 in every state except IDLE.
- Atomicity: host is locked out from the end of REQ (read issued) through WB. Max host wait after a grant loss is 3 cycles.
- Counters saturate at 2**CNT_W-1.
- i_clr takes effect in any state and wins over a same-cycle increment or capture.
- i_start while busy is ignored.
- Reset mid-pass aborts immediately. A half-finished writeback is not retried.
- Decode latency: CHK is the only decode cycle. Per-word cost is 3 cycles if clean or DED, 4 if SEC, plus host stalls.

Decomposition:
- Shared package ecc_pkg: function calc_m(k), derived N, FSM state enum, error-type encoding (NONE/SEC/DED).
- One sub-module, secded_dec: combinational N-bit decoder with outputs corrected codeword, sec flag and ded flag. This is the same decode as the team's hamming_secded datapath, operating on the full codeword.

Test Plan:
- Clean memory of 16 codewords, i_start: 16×3 read cycles, o_done pulses exactly once, counters 0, no writes.
- Address 5 has data bit 2 flipped: exactly one write to addr 5 with the corrected codeword; o_sec_cnt=1; rereading addr 5 decodes clean.
- Addresses 3 and 9 have two bits flipped each: no writes; o_ded_cnt=2, o_ded_addr=3, o_ded_valid=1.
- i_host_req held high 10 cycles while in REQ: o_host_gnt=1, o_mem_en=0 throughout, scrub resumes at the same address. Asserting i_host_req during WAIT/CHK/WB gives o_host_gnt=0 until WB completes.
- All 16 addresses SEC with CNT_W=4: o_sec_cnt saturates at 15. i_clr asserted on the same cycle as an increment leaves the count at 0.
- i_rst_n low mid-WB at addr 7: all outputs 0 immediately. A fresh i_start restarts at addr 0.
